// File: rtl/core_pkg.sv
// core_pkg: shared return-tracking state and write-enable constants
package core_pkg;
  typedef enum logic [1:0] {RET_NONE, RET_IF, RET_D} ret_state_t;
  localparam logic [3:0] WE_NONE = 4'b0000;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between fetch and data ports
module mem_port_arbiter
  import core_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MAX_D_RUN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic [3:0]        d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);
  ret_state_t ret, ret_nxt;
  logic [3:0] d_run, d_run_nxt;
  logic [DATA_W-1:0] if_q, d_q;
  logic f_turn;
  always_comb begin
    f_turn = d_run == 4'(MAX_D_RUN);
    d_gnt = ~rst & d_req & ~(if_req & f_turn);
    if_gnt = ~rst & if_req & ~d_gnt;
    mem_en = if_gnt | d_gnt;
    mem_we = d_gnt ? d_we : WE_NONE;
    mem_addr = d_gnt ? d_addr : if_gnt ? if_addr : '0;
    mem_wdata = d_gnt ? d_wdata : '0;
    stall = (if_req & ~if_gnt) | (d_req & ~d_gnt);
    ret_nxt = if_gnt ? RET_IF : (d_gnt && d_we == WE_NONE) ? RET_D : RET_NONE;
    // a data grant with fetch waiting implies d_run < MAX_D_RUN, so this saturates
    d_run_nxt = (~if_req | if_gnt) ? 4'd0 : d_gnt ? d_run + 4'd1 : d_run;
    // reset drops a return that lands in the reset cycle
    if_rvalid = ~rst & (ret == RET_IF);
    d_rvalid = ~rst & (ret == RET_D);
    if_rdata = if_rvalid ? mem_rdata : if_q;
    d_rdata = d_rvalid ? mem_rdata : d_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ret <= RET_NONE;
      d_run <= 4'd0;
      if_q <= '0;
      d_q <= '0;
    end else begin
      ret <= ret_nxt;
      d_run <= d_run_nxt;
      if (if_rvalid) if_q <= mem_rdata;
      if (d_rvalid) d_q <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed plus random stimulus against a transaction-level model
module tb_mem_port_arbiter;
  localparam int MAX = 4;
  logic clk = 0, rst = 1;
  logic if_req = 0, d_req = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata;
  logic [3:0] d_we = 0, mem_we;
  logic if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, stall;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  always #5 clk = ~clk;
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_RUN(MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall(stall)
  );
  logic [31:0] bmem [256];
  logic [31:0] mm [256];
  always @(posedge clk) begin
    if (mem_en && mem_we == 4'b0) mem_rdata <= bmem[mem_addr[9:2]];
    else mem_rdata <= $urandom;
    if (mem_en)
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) bmem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
  end
  int checks = 0, errors = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask
  int run = 0, ret = 0;
  logic [31:0] ret_word = 0, held_if = 0, held_d = 0;
  bit eig = 0, edg = 0;
  task automatic step(input bit r, input bit ir, input logic [31:0] ia, input bit dr,
                      input logic [3:0] we, input logic [31:0] da, input logic [31:0] wd);
    bit fetch_wins, eifv, edv;
    int idx;
    @(negedge clk);
    rst = r; if_req = ir; if_addr = ia; d_req = dr; d_we = we; d_addr = da; d_wdata = wd;
    #1;
    fetch_wins = ir && (!dr || run == MAX);
    eig = !r && fetch_wins;
    edg = !r && dr && !fetch_wins;
    eifv = !r && ret == 1;
    edv = !r && ret == 2;
    chk("if_gnt", if_gnt, eig);
    chk("d_gnt", d_gnt, edg);
    chk("stall", stall, (ir && !eig) || (dr && !edg));
    chk("mem_en", mem_en, eig || edg);
    chk("mem_we", mem_we, edg ? we : 4'b0);
    chk("mem_addr", mem_addr, edg ? da : eig ? ia : 32'b0);
    chk("mem_wdata", mem_wdata, edg ? wd : 32'b0);
    chk("if_rvalid", if_rvalid, eifv);
    chk("d_rvalid", d_rvalid, edv);
    chk("if_rdata", if_rdata, eifv ? ret_word : held_if);
    chk("d_rdata", d_rdata, edv ? ret_word : held_d);
    if (eifv) held_if = ret_word;
    if (edv) held_d = ret_word;
    if (r) begin
      run = 0; ret = 0; held_if = 0; held_d = 0;
    end else begin
      idx = eig ? int'(ia[9:2]) : int'(da[9:2]);
      ret = eig ? 1 : (edg && we == 4'b0) ? 2 : 0;
      if (ret != 0) ret_word = mm[idx];
      if (edg)
        for (int b = 0; b < 4; b++)
          if (we[b]) mm[idx][8*b +: 8] = wd[8*b +: 8];
      run = (!ir || eig) ? 0 : edg ? (run < MAX ? run + 1 : MAX) : run;
    end
  endtask
  initial begin
    bit ir, dr, r;
    logic [31:0] ia, da, wd;
    logic [3:0] we;
    for (int i = 0; i < 256; i++) begin
      bmem[i] = $urandom;
      mm[i] = bmem[i];
    end
    bmem[64] = 32'h00500093; mm[64] = 32'h00500093;
    bmem[128] = 32'hDEADBEEF; mm[128] = 32'hDEADBEEF;
    bmem[129] = 32'h12345678; mm[129] = 32'h12345678;
    step(1, 1, 32'h100, 1, 4'b0, 32'h200, 0);
    step(1, 1, 32'h100, 1, 4'b0, 32'h200, 0);
    chk("rst_stall", stall, 1);
    step(0, 1, 32'h100, 0, 4'b0, 0, 0);
    chk("sc1_gnt", if_gnt, 1);
    step(0, 0, 0, 0, 4'b0, 0, 0);
    chk("sc1_data", if_rdata, 32'h00500093);
    step(0, 1, 32'h100, 1, 4'b0, 32'h200, 0);
    chk("sc2_stall", stall, 1);
    step(0, 1, 32'h100, 0, 4'b0, 0, 0);
    chk("sc2_d", d_rdata, 32'hDEADBEEF);
    chk("sc2_nostall", stall, 0);
    step(0, 0, 0, 1, 4'b0011, 32'h204, 32'h0000ABCD);
    chk("sc3_we", mem_we, 4'b0011);
    step(0, 1, 32'h204, 0, 4'b0, 0, 0);
    chk("sc3_nrv", d_rvalid, 0);
    step(0, 0, 0, 0, 4'b0, 0, 0);
    chk("sc3_rd", if_rdata, 32'h1234ABCD);
    for (int k = 0; k < 15; k++) begin
      step(0, 1, 32'h100, 1, 4'b0, 32'h200, 0);
      chk("sc4_pat", d_gnt, (k % 5) != 4);
    end
    step(0, 0, 0, 0, 4'b0, 0, 0);
    step(0, 0, 0, 1, 4'b0, 32'h200, 0);
    step(1, 0, 0, 0, 4'b0, 0, 0);
    chk("sc5_drop", d_rvalid, 0);
    step(0, 0, 0, 0, 4'b0, 0, 0);
    chk("sc5_ifq", if_rdata, 0);
    chk("sc5_dq", d_rdata, 0);
    step(0, 1, 32'h100, 0, 4'b0, 0, 0);
    step(0, 0, 0, 0, 4'b0, 0, 0);
    chk("sc5_fetch", if_rdata, 32'h00500093);
    ir = 0; dr = 0; ia = 0; da = 0; wd = 0; we = 0;
    for (int k = 0; k < 600; k++) begin
      r = $urandom_range(0, 63) == 0;
      if (!ir || eig) begin
        ir = $urandom_range(0, 1) == 1;
        ia = {22'b0, 8'($urandom_range(0, 255)), 2'b0};
      end
      if (!dr || edg) begin
        dr = $urandom_range(0, 3) != 0;
        we = $urandom_range(0, 2) == 0 ? 4'($urandom) : 4'b0;
        da = {22'b0, 8'($urandom_range(0, 255)), 2'b0};
        wd = $urandom;
      end
      step(r, ir, ia, dr, we, da, wd);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
